// File: rtl/dmac_channel_datapath_p.sv
// DMA channel datapath: read side fills an internal FIFO, write side drains it.
// Each side has its own address generator, burst sizing and beat counting.
module dmac_channel_datapath_p #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned NL        = DATA_W / 8,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] cfg_src_addr,
    input  logic [ADDR_W-1:0] cfg_dst_addr,
    input  logic [CNT_W-1:0]  cfg_beats,
    input  logic [1:0]        cfg_burst,
    input  logic              cfg_src_inc,
    input  logic              cfg_dst_inc,
    input  logic [2:0]        cfg_hsize,
    input  logic              rd_start,
    input  logic              rd_beat,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              wr_start,
    input  logic              wr_beat,
    input  logic              h_sel,
    output logic [ADDR_W-1:0] m_addr,
    output logic [2:0]        m_hburst,
    output logic [2:0]        m_hsize,
    output logic [DATA_W-1:0] m_wdata,
    output logic [NL-1:0]     m_wstrb,
    output logic [4:0]        rd_len,
    output logic [4:0]        wr_len,
    output logic              rd_last,
    output logic              wr_last,
    output logic              rd_ok,
    output logic              wr_ok,
    output logic              rd_done,
    output logic              wr_done,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OFF_W = $clog2(NL);

    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic [CNT_W-1:0]  rd_rem, wr_rem;
    logic [4:0]        rd_cnt, wr_cnt;
    logic [1:0]        burst_q;
    logic              src_inc_q, dst_inc_q;
    logic [2:0]        hsize_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [LVL_W-1:0]  level;

    logic [4:0]        blen, rd_cand, wr_cand, sel_len;
    logic [ADDR_W-1:0] addr_step;
    logic [OFF_W-1:0]  lane_off;
    logic [3:0]        size_b;
    logic              misaligned;
    logic [NL-1:0]     strb;
    logic              push, pop;

    always_comb begin
        unique case (burst_q)
            2'd0:    blen = 5'd1;
            2'd1:    blen = 5'd4;
            2'd2:    blen = 5'd8;
            default: blen = 5'd16;
        endcase
    end

    // Remainders shorter than a full burst are moved as single beats.
    assign rd_cand = (rd_rem >= CNT_W'(blen)) ? blen : 5'd1;
    assign wr_cand = (wr_rem >= CNT_W'(blen)) ? blen : 5'd1;

    assign fifo_level = level;
    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign m_wdata    = mem[rptr];
    assign m_hsize    = hsize_q;

    assign rd_ok = !rd_done && ((LVL_W'(FIFO_DEPTH) - level) >= LVL_W'(rd_cand));
    assign wr_ok = !wr_done && (level >= LVL_W'(wr_cand));

    assign rd_last = rd_beat && (rd_cnt == 5'd1);
    assign wr_last = wr_beat && (wr_cnt == 5'd1);

    assign m_addr  = h_sel ? dst_addr : src_addr;
    assign sel_len = h_sel ? wr_len : rd_len;

    always_comb begin
        case (sel_len)
            5'd4:    m_hburst = 3'b011;
            5'd8:    m_hburst = 3'b101;
            5'd16:   m_hburst = 3'b111;
            default: m_hburst = 3'b000;
        endcase
    end

    assign addr_step = ADDR_W'(1) << hsize_q;
    assign lane_off  = dst_addr[OFF_W-1:0];
    assign size_b    = 4'(1) << hsize_q;
    // A full-width beat shifts the mask to zero, so all lane bits must be clear.
    assign misaligned = (lane_off & ((OFF_W'(1) << hsize_q) - OFF_W'(1))) != '0;

    always_comb begin
        strb = '0;
        for (int i = 0; i < NL; i++) begin
            strb[i] = (i >= int'(lane_off)) && (i < int'(lane_off) + int'(size_b));
        end
    end

    assign m_wstrb = (h_sel && !fifo_empty && !misaligned) ? strb : '0;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is allowed then.
    assign pop  = wr_beat && !fifo_empty;
    assign push = rd_beat && (!fifo_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_addr  <= '0;
            dst_addr  <= '0;
            rd_rem    <= '0;
            wr_rem    <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            rd_len    <= '0;
            wr_len    <= '0;
            burst_q   <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            hsize_q   <= '0;
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            rd_done   <= 1'b1;
            wr_done   <= 1'b1;
            err       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (cfg_load) begin
            src_addr  <= cfg_src_addr;
            dst_addr  <= cfg_dst_addr;
            rd_rem    <= cfg_beats;
            wr_rem    <= cfg_beats;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            rd_len    <= '0;
            wr_len    <= '0;
            burst_q   <= cfg_burst;
            src_inc_q <= cfg_src_inc;
            dst_inc_q <= cfg_dst_inc;
            hsize_q   <= cfg_hsize;
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            rd_done   <= (cfg_beats == '0);
            wr_done   <= (cfg_beats == '0);
            err       <= 1'b0;
        end else begin
            if (rd_start && !rd_done) begin
                rd_len <= rd_cand;
                rd_cnt <= rd_cand;
            end else if (rd_beat && rd_cnt != '0) begin
                rd_cnt <= rd_cnt - 5'd1;
            end
            if (wr_start && !wr_done) begin
                wr_len <= wr_cand;
                wr_cnt <= wr_cand;
            end else if (pop && wr_cnt != '0) begin
                wr_cnt <= wr_cnt - 5'd1;
            end

            if (rd_beat && !rd_done) begin
                rd_rem  <= rd_rem - CNT_W'(1);
                rd_done <= (rd_rem == CNT_W'(1));
                if (src_inc_q) src_addr <= src_addr + addr_step;
            end
            if (pop && !wr_done) begin
                wr_rem  <= wr_rem - CNT_W'(1);
                wr_done <= (wr_rem == CNT_W'(1));
                if (dst_inc_q) dst_addr <= dst_addr + addr_step;
            end

            if (push) begin
                mem[wptr] <= rd_data;
                wptr      <= wptr + PTR_W'(1);
            end
            if (pop) rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            if ((rd_beat && !push) || (wr_beat && (!pop || misaligned))) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmac_channel_datapath_p.sv
// Randomised bench for dmac_channel_datapath_p against a queue-based transfer model.
module tb_dmac_channel_datapath_p;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 0, cfg_src_inc = 0, cfg_dst_inc = 0;
    logic [31:0] cfg_src_addr = 0, cfg_dst_addr = 0;
    logic [15:0] cfg_beats = 0;
    logic [1:0]  cfg_burst = 0;
    logic [2:0]  cfg_hsize = 0;
    logic        rd_start = 0, rd_beat = 0, wr_start = 0, wr_beat = 0, h_sel = 0;
    logic [31:0] rd_data = 0;
    logic [31:0] m_addr, m_wdata;
    logic [2:0]  m_hburst, m_hsize;
    logic [3:0]  m_wstrb;
    logic [4:0]  rd_len, wr_len, fifo_level;
    logic        rd_last, wr_last, rd_ok, wr_ok, rd_done, wr_done;
    logic        fifo_full, fifo_empty, err;

    int total = 0;
    int bad = 0;
    int rd_lens[$];
    logic [31:0] q[$];

    dmac_channel_datapath_p dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_src_addr(cfg_src_addr),
        .cfg_dst_addr(cfg_dst_addr), .cfg_beats(cfg_beats), .cfg_burst(cfg_burst),
        .cfg_src_inc(cfg_src_inc), .cfg_dst_inc(cfg_dst_inc), .cfg_hsize(cfg_hsize),
        .rd_start(rd_start), .rd_beat(rd_beat), .rd_data(rd_data), .wr_start(wr_start),
        .wr_beat(wr_beat), .h_sel(h_sel), .m_addr(m_addr), .m_hburst(m_hburst),
        .m_hsize(m_hsize), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .rd_len(rd_len),
        .wr_len(wr_len), .rd_last(rd_last), .wr_last(wr_last), .rd_ok(rd_ok), .wr_ok(wr_ok),
        .rd_done(rd_done), .wr_done(wr_done), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_level(fifo_level), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int blen(input logic [1:0] b);
        return (b == 2'd0) ? 1 : (2 << b);
    endfunction

    function automatic int cand(input int rem, input logic [1:0] b);
        return (rem >= blen(b)) ? blen(b) : 1;
    endfunction

    function automatic logic [2:0] code(input int n);
        case (n)
            4:       return 3'b011;
            8:       return 3'b101;
            16:      return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] exp_strb(input logic [31:0] a, input logic [2:0] hs);
        int sz;
        int off;
        sz  = 1 << hs;
        off = int'(a % 32'd4);
        if (off % sz != 0) return 4'b0000;
        return 4'(((1 << sz) - 1) << off);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] s, input logic [31:0] d, input int beats,
                        input logic [1:0] b, input logic si, input logic di,
                        input logic [2:0] hs);
        cfg_src_addr = s; cfg_dst_addr = d; cfg_beats = 16'(beats); cfg_burst = b;
        cfg_src_inc = si; cfg_dst_inc = di; cfg_hsize = hs; cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        q.delete();
        rd_lens.delete();
    endtask

    // Moves a whole transfer with random read/write burst interleaving.
    task automatic run_transfer(input logic [31:0] s, input logic [31:0] d, input int beats,
                                input logic [1:0] b, input logic si, input logic di,
                                input logic [2:0] hs);
        int rrem, wrem, n, cr, cw, guard;
        bit can_r, can_w;
        logic [31:0] ms, md, dv;
        load(s, d, beats, b, si, di, hs);
        ms = s; md = d; rrem = beats; wrem = beats; guard = 0;
        total++;
        if (m_hsize !== hs) begin
            bad++; $display("FAIL hsize: got %0d want %0d", m_hsize, hs);
        end
        while ((rrem > 0 || wrem > 0) && guard < 500) begin
            guard++;
            cr = (rrem > 0) ? cand(rrem, b) : 0;
            cw = (wrem > 0) ? cand(wrem, b) : 0;
            can_r = (rrem > 0) && (DEPTH - q.size() >= cr);
            can_w = (wrem > 0) && (q.size() >= cw);
            total += 4;
            if (rd_ok !== can_r) begin bad++; $display("FAIL rd_ok: got %b want %b", rd_ok, can_r); end
            if (wr_ok !== can_w) begin bad++; $display("FAIL wr_ok: got %b want %b", wr_ok, can_w); end
            if (fifo_level !== 5'(q.size())) begin
                bad++; $display("FAIL level: got %0d want %0d", fifo_level, q.size());
            end
            if (rd_done !== (rrem == 0)) begin
                bad++; $display("FAIL rd_done: got %b want %b", rd_done, rrem == 0);
            end
            if (can_r && (!can_w || $urandom_range(1, 0) == 1)) begin
                n = cr;
                h_sel = 1'b0; rd_start = 1'b1; step(); rd_start = 1'b0;
                rd_lens.push_back(n);
                total += 2;
                if (rd_len !== 5'(n)) begin bad++; $display("FAIL rd_len: got %0d want %0d", rd_len, n); end
                if (m_hburst !== code(n)) begin
                    bad++; $display("FAIL rd_hburst: got %b want %b", m_hburst, code(n));
                end
                for (int i = 0; i < n; i++) begin
                    total += 2;
                    if (m_addr !== ms) begin bad++; $display("FAIL src_addr: got %h want %h", m_addr, ms); end
                    dv = $urandom; rd_data = dv; rd_beat = 1'b1; #1;
                    if (rd_last !== (i == n - 1)) begin
                        bad++; $display("FAIL rd_last: got %b want %b", rd_last, i == n - 1);
                    end
                    step(); rd_beat = 1'b0;
                    q.push_back(dv); rrem--;
                    if (si) ms = ms + (32'd1 << hs);
                end
            end else if (can_w) begin
                n = cw;
                h_sel = 1'b1; wr_start = 1'b1; step(); wr_start = 1'b0;
                total += 2;
                if (wr_len !== 5'(n)) begin bad++; $display("FAIL wr_len: got %0d want %0d", wr_len, n); end
                if (m_hburst !== code(n)) begin
                    bad++; $display("FAIL wr_hburst: got %b want %b", m_hburst, code(n));
                end
                for (int i = 0; i < n; i++) begin
                    total += 4;
                    if (m_addr !== md) begin bad++; $display("FAIL dst_addr: got %h want %h", m_addr, md); end
                    if (m_wdata !== q[0]) begin bad++; $display("FAIL wdata: got %h want %h", m_wdata, q[0]); end
                    if (m_wstrb !== exp_strb(md, hs)) begin
                        bad++; $display("FAIL wstrb: got %b want %b", m_wstrb, exp_strb(md, hs));
                    end
                    wr_beat = 1'b1; #1;
                    if (wr_last !== (i == n - 1)) begin
                        bad++; $display("FAIL wr_last: got %b want %b", wr_last, i == n - 1);
                    end
                    step(); wr_beat = 1'b0;
                    void'(q.pop_front()); wrem--;
                    if (di) md = md + (32'd1 << hs);
                end
            end else begin
                total++; bad++;
                $display("FAIL deadlock: got no legal burst want progress (rrem=%0d wrem=%0d)", rrem, wrem);
                break;
            end
        end
        h_sel = 1'b0; #1;
        total += 6;
        if (m_addr !== ms) begin bad++; $display("FAIL end_src: got %h want %h", m_addr, ms); end
        h_sel = 1'b1; #1;
        if (m_addr !== md) begin bad++; $display("FAIL end_dst: got %h want %h", m_addr, md); end
        if (rd_done !== 1'b1) begin bad++; $display("FAIL end_rd_done: got %b want 1", rd_done); end
        if (wr_done !== 1'b1) begin bad++; $display("FAIL end_wr_done: got %b want 1", wr_done); end
        if (err !== 1'b0) begin bad++; $display("FAIL end_err: got %b want 0", err); end
        if (fifo_empty !== 1'b1) begin bad++; $display("FAIL end_empty: got %b want 1", fifo_empty); end
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0; h_sel = 1'b1; #1;
        total += 7;
        if (rd_done !== 1'b1) begin bad++; $display("FAIL rst_rd_done: got %b want 1", rd_done); end
        if (wr_done !== 1'b1) begin bad++; $display("FAIL rst_wr_done: got %b want 1", wr_done); end
        if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        if (m_wstrb !== 4'b0) begin bad++; $display("FAIL rst_wstrb: got %b want 0", m_wstrb); end
        if (m_hburst !== 3'b0) begin bad++; $display("FAIL rst_hburst: got %b want 0", m_hburst); end
        if (fifo_level !== 5'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        if (m_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", m_addr); end
    endtask

    task automatic test_aligned();
        int n8;
        run_transfer(32'h1000, 32'h2000, 32, 2'd2, 1'b1, 1'b1, 3'd2);
        n8 = 0;
        foreach (rd_lens[i]) if (rd_lens[i] == 8) n8++;
        total += 3;
        if (n8 !== 4 || rd_lens.size() !== 4) begin
            bad++; $display("FAIL aligned_bursts: got %0d of %0d want 4 of 4", n8, rd_lens.size());
        end
        h_sel = 1'b0; #1;
        if (m_addr !== 32'h1080) begin bad++; $display("FAIL aligned_src: got %h want 1080", m_addr); end
        h_sel = 1'b1; #1;
        if (m_addr !== 32'h2080) begin bad++; $display("FAIL aligned_dst: got %h want 2080", m_addr); end
    endtask

    task automatic test_tail();
        int exp_lens[4];
        exp_lens = '{4, 4, 1, 1};
        run_transfer(32'h500, 32'h900, 10, 2'd1, 1'b1, 1'b1, 3'd2);
        total++;
        if (rd_lens.size() !== 4) begin
            bad++; $display("FAIL tail_count: got %0d want 4", rd_lens.size());
        end else begin
            foreach (exp_lens[i]) begin
                total++;
                if (rd_lens[i] !== exp_lens[i]) begin
                    bad++; $display("FAIL tail_len[%0d]: got %0d want %0d", i, rd_lens[i], exp_lens[i]);
                end
            end
        end
    endtask

    task automatic test_fixed();
        run_transfer(32'h80, 32'h4000_0010, 6, 2'd1, 1'b1, 1'b0, 3'd2);
    endtask

    task automatic test_strobes();
        load(32'h0, 32'h3, 2, 2'd0, 1'b1, 1'b1, 3'd0);
        h_sel = 1'b0; rd_start = 1'b1; step(); rd_start = 1'b0;
        rd_data = 32'h11; rd_beat = 1'b1; step(); rd_beat = 1'b0;
        rd_start = 1'b1; step(); rd_start = 1'b0;
        rd_data = 32'h22; rd_beat = 1'b1; step(); rd_beat = 1'b0;
        #1;
        total += 3;
        if (m_wstrb !== 4'b0000) begin bad++; $display("FAIL strb_hsel0: got %b want 0000", m_wstrb); end
        h_sel = 1'b1; #1;
        if (m_wstrb !== 4'b1000) begin bad++; $display("FAIL strb_b3: got %b want 1000", m_wstrb); end
        wr_start = 1'b1; step(); wr_start = 1'b0;
        wr_beat = 1'b1; step(); wr_beat = 1'b0;
        if (m_wstrb !== 4'b0001) begin bad++; $display("FAIL strb_b4: got %b want 0001", m_wstrb); end
        // Halfword to an odd address
        load(32'h0, 32'h1, 1, 2'd0, 1'b1, 1'b1, 3'd1);
        h_sel = 1'b0; rd_start = 1'b1; step(); rd_start = 1'b0;
        rd_data = 32'h33; rd_beat = 1'b1; step(); rd_beat = 1'b0;
        h_sel = 1'b1; #1;
        total += 3;
        if (m_wstrb !== 4'b0000) begin bad++; $display("FAIL strb_mis: got %b want 0000", m_wstrb); end
        if (err !== 1'b0) begin bad++; $display("FAIL mis_err_pre: got %b want 0", err); end
        wr_start = 1'b1; step(); wr_start = 1'b0;
        wr_beat = 1'b1; step(); wr_beat = 1'b0;
        if (err !== 1'b1) begin bad++; $display("FAIL mis_err: got %b want 1", err); end
    endtask

    task automatic test_fifo_boundary();
        logic [31:0] dv;
        load(32'h100, 32'h200, 40, 2'd3, 1'b1, 1'b1, 3'd2);
        h_sel = 1'b0; rd_start = 1'b1; step(); rd_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dv = $urandom; rd_data = dv; rd_beat = 1'b1; step(); rd_beat = 1'b0;
            q.push_back(dv);
        end
        total += 6;
        if (fifo_full !== 1'b1) begin bad++; $display("FAIL full: got %b want 1", fifo_full); end
        if (fifo_level !== 5'd16) begin bad++; $display("FAIL full_level: got %0d want 16", fifo_level); end
        if (rd_ok !== 1'b0) begin bad++; $display("FAIL full_rd_ok: got %b want 0", rd_ok); end
        rd_data = $urandom; rd_beat = 1'b1; step(); rd_beat = 1'b0;
        if (err !== 1'b1) begin bad++; $display("FAIL ovf_err: got %b want 1", err); end
        if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
        if (wr_ok !== 1'b1) begin bad++; $display("FAIL full_wr_ok: got %b want 1", wr_ok); end
        h_sel = 1'b1; wr_start = 1'b1; step(); wr_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total += 3;
            if (m_wdata !== q[0]) begin bad++; $display("FAIL rw_wdata: got %h want %h", m_wdata, q[0]); end
            dv = $urandom; rd_data = dv; rd_beat = 1'b1; wr_beat = 1'b1; step();
            rd_beat = 1'b0; wr_beat = 1'b0;
            void'(q.pop_front()); q.push_back(dv);
            if (fifo_level !== 5'd16) begin bad++; $display("FAIL rw_level: got %0d want 16", fifo_level); end
            if (fifo_full !== 1'b1) begin bad++; $display("FAIL rw_full: got %b want 1", fifo_full); end
        end
    endtask

    task automatic test_reset_mid();
        load(32'h1000, 32'h2000, 20, 2'd1, 1'b1, 1'b1, 3'd2);
        h_sel = 1'b0; rd_start = 1'b1; step(); rd_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_data = $urandom; rd_beat = 1'b1; step(); rd_beat = 1'b0;
        end
        total += 2;
        if (fifo_level !== 5'd5) begin bad++; $display("FAIL pre_rst_level: got %0d want 5", fifo_level); end
        rst = 1'b1; #2;
        if (fifo_level !== 5'd0) begin bad++; $display("FAIL async_rst_level: got %0d want 0", fifo_level); end
        step(); rst = 1'b0; step();
        total += 5;
        if (m_addr !== 32'h0) begin bad++; $display("FAIL rst_src: got %h want 0", m_addr); end
        h_sel = 1'b1; #1;
        if (m_addr !== 32'h0) begin bad++; $display("FAIL rst_dst: got %h want 0", m_addr); end
        if (rd_done !== 1'b1) begin bad++; $display("FAIL mid_rd_done: got %b want 1", rd_done); end
        if (err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", err); end
        if (fifo_empty !== 1'b1) begin bad++; $display("FAIL mid_empty: got %b want 1", fifo_empty); end
        load(32'h10, 32'h20, 0, 2'd2, 1'b1, 1'b1, 3'd2);
        total += 6;
        if (rd_done !== 1'b1) begin bad++; $display("FAIL zero_rd_done: got %b want 1", rd_done); end
        if (wr_done !== 1'b1) begin bad++; $display("FAIL zero_wr_done: got %b want 1", wr_done); end
        if (rd_ok !== 1'b0) begin bad++; $display("FAIL zero_rd_ok: got %b want 0", rd_ok); end
        h_sel = 1'b0; rd_start = 1'b1; step(); rd_start = 1'b0;
        if (rd_len !== 5'd0) begin bad++; $display("FAIL zero_rd_len: got %0d want 0", rd_len); end
        if (m_hburst !== 3'b000) begin bad++; $display("FAIL zero_hburst: got %b want 000", m_hburst); end
        if (rd_done !== 1'b1) begin bad++; $display("FAIL zero_rd_done2: got %b want 1", rd_done); end
    endtask

    task automatic test_random();
        logic [2:0]  hs;
        logic [31:0] s, d, mask;
        for (int k = 0; k < 5; k++) begin
            hs   = 3'($urandom_range(2, 0));
            mask = ~((32'd1 << hs) - 32'd1);
            s    = $urandom & mask;
            d    = (k == 0) ? 32'hFFFF_FFF8 : ($urandom & mask);
            run_transfer(s, d, int'($urandom_range(40, 1)), 2'($urandom_range(3, 0)),
                         1'($urandom_range(1, 0)), (k == 0) ? 1'b1 : 1'($urandom_range(1, 0)), hs);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_tail();
        test_fixed();
        test_strobes();
        test_fifo_boundary();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/dmac_channel_datapath_p.md
Name: dmac_channel_datapath_p

Overview:
Parametrised next-generation DMA channel datapath with independent read and write sides.
- Read side: fetches beats from the source into an internal FIFO.
- Write side: drains the FIFO to the destination.
- Per-side address generation with fixed or incrementing mode, configurable transfer width, AHB-coded burst selection with single-beat tail handling, and sticky error reporting.
- Sits between the channel controller FSM and the AHB master port mux.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data bus width (32 or 64); byte lanes NL = DATA_W/8.
FIFO_DEPTH, 16, FIFO entries (power of 2, ≥16).
CNT_W, 16, width of the transfer beat counters.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_load  in  1  load all cfg_* fields, start a new transfer
cfg_src_addr  in  ADDR_W  source start address
cfg_dst_addr  in  ADDR_W  destination start address
cfg_beats  in  CNT_W  total beats to move
cfg_burst  in  2  burst length: 0=1, 1=4, 2=8, 3=16
cfg_src_inc  in  1  1=increment source address, 0=fixed
cfg_dst_inc  in  1  1=increment destination address, 0=fixed
cfg_hsize  in  3  beat size, log2 bytes, ≤ log2(NL)
rd_start  in  1  controller begins a read burst
rd_beat  in  1  source beat accepted with valid rd_data
rd_data  in  DATA_W  source read data
wr_start  in  1  controller begins a write burst
wr_beat  in  1  destination beat accepted
h_sel  in  1  0=drive source address, 1=drive destination address
m_addr  out  ADDR_W  bus address
m_hburst  out  3  AHB HBURST for the current side
m_hsize  out  3  registered cfg_hsize
m_wdata  out  DATA_W  FIFO head
m_wstrb  out  NL  byte strobes
rd_len  out  5  beats in the current read burst
wr_len  out  5  beats in the current write burst
rd_last  out  1  current rd_beat ends the read burst
wr_last  out  1  current wr_beat ends the write burst
rd_ok  out  1  read burst may start
wr_ok  out  1  write burst may start
rd_done  out  1  all read beats fetched
wr_done  out  1  all write beats written
fifo_full  out  1  FIFO full
fifo_empty  out  1  FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
err  out  1  sticky overflow/underflow

Behaviour:
Reset:
- All registers 0; FIFO empty.
- rd_done=wr_done=1, err=0, m_wstrb=0, m_hburst=000.

cfg_load (one cycle):
- Loads the address registers.
- rd_rem=wr_rem=cfg_beats; rd_done=wr_done=(cfg_beats==0).
- Clears err and flushes the FIFO.
- cfg_load overrides every other input in the same cycle.

Burst length:
- B = 1/4/8/16 per cfg_burst.
- On rd_start: rd_len = B if rd_rem≥B, else 1. The tail is always sent as singles.
- Same rule for wr_start with wr_rem.
- rd_len/wr_len hold until the next start.
- rd_start is ignored while rd_done=1; wr_start likewise with wr_done.

Burst permission:
- rd_ok = !rd_done && (FIFO_DEPTH - fifo_level) ≥ candidate rd_len.
- wr_ok = !wr_done && fifo_level ≥ candidate wr_len.
- The candidate is the length that would be chosen on the next start.

Beat counters:
- A beat counter counts down within each burst.
- rd_last is asserted combinationally when the counter = 1 and rd_beat=1; wr_last likewise.

rd_beat:
- Pushes rd_data.
- Decrements rd_rem; rd_done sets when rd_rem reaches 0.
- If cfg_src_inc=1, source address += 1<<hsize.

wr_beat:
- Pops the FIFO.
- Decrements wr_rem, with wr_done set likewise.
- Advances the destination address per cfg_dst_inc.
- Address arithmetic wraps modulo 2^ADDR_W; no 1 KB boundary splitting.

Simultaneous rd_beat and wr_beat:
- Push and pop occur together; level is unchanged.
- A simultaneous push/pop on an empty FIFO is not allowed: the pop raises err, and the push still proceeds.

Errors and FIFO:
- rd_beat while full: data dropped, err=1.
- wr_beat while empty: err=1, state unchanged.
- FIFO read data is first-word-fall-through. m_wdata = head, combinational from the registered memory.

Bus outputs:
- m_addr = h_sel ? dst_addr : src_addr.
- m_hburst = SINGLE 000, INCR4 011, INCR8 101, INCR16 111 for the selected side's current length.
- m_wstrb = ((1<<(1<<hsize))-1) << (dst_addr mod NL), masked to NL bits.
- m_wstrb is forced 0 when h_sel=0 or the FIFO is empty.
- Misaligned dst_addr for hsize: m_wstrb=0 and err=1 on wr_beat.

Reset mid-transfer: returns immediately to reset values; FIFO contents are discarded.

Test Plan:
- Aligned burst: cfg_beats=32, burst=INCR8, src 0x1000 inc, dst 0x2000 inc, hsize=2. Expect four read bursts, rd_len=8, m_hburst=101. Final src=0x1080, dst=0x2080, rd_done/wr_done=1, err=0, data order preserved.
- Tail: cfg_beats=10, burst=INCR4. Expect rd_len sequence 4,4,1,1 and m_hburst 011,011,000,000; rd_done after beat 10.
- Fixed address: cfg_dst_inc=0, dst=0x4000_0010, 6 beats. Expect m_addr stays 0x4000_0010 on every write beat.
- Strobes: hsize=0, dst=0x3, DATA_W=32. Expect m_wstrb=1000, then 0001 after one beat (dst=0x4). hsize=1 with dst=0x1: expect m_wstrb=0 and err=1 on wr_beat.
- FIFO boundary: push 16 beats with no writes. Expect fifo_full=1, rd_ok=0; a 17th rd_beat sets err=1 and level stays 16. Then simultaneous rd/wr beats keep level at 16.
- Reset: assert rst mid-burst (level=5). Expect level=0, rd_done=1, addresses 0, err=0. Then cfg_beats=0: expect rd_done=wr_done=1, and rd_start is ignored.
